// File: rtl/ppi_portb_mode1_ctrl_if.sv
// Port B bus/handshake bundle: CPU strobes and data, Port B and PC2/PC1/PC0 pins, status.
// The master drives the stimulus side; the slave is the sequencer.
interface ppi_portb_mode1_ctrl_if;
    logic       Wr_Ctrl;
    logic [7:0] Bus;
    logic       Wr_PortB;
    logic       Rd_PortB;
    logic [7:0] Cpu_Data;
    logic [7:0] Pin_B;
    logic       Stb_n;
    logic       Ack_n;
    logic [7:0] Pb_Out;
    logic       Pb_Oe;
    logic [7:0] Rd_Data;
    logic       Mode1;
    logic       Dir_In;
    logic       Inte;
    logic       Ibf;
    logic       Obf_n;
    logic       Intr;
    logic       Overrun;
    logic [2:0] Dbg_State;

    // Strobes are one-cycle pulses sampled on the rising clock edge.
    // There is no back-pressure, so there is no ready signal.
    modport master (
        output Wr_Ctrl, Bus, Wr_PortB, Rd_PortB, Cpu_Data, Pin_B, Stb_n, Ack_n,
        input  Pb_Out, Pb_Oe, Rd_Data, Mode1, Dir_In, Inte, Ibf, Obf_n, Intr,
               Overrun, Dbg_State
    );

    modport slave (
        input  Wr_Ctrl, Bus, Wr_PortB, Rd_PortB, Cpu_Data, Pin_B, Stb_n, Ack_n,
        output Pb_Out, Pb_Oe, Rd_Data, Mode1, Dir_In, Inte, Ibf, Obf_n, Intr,
               Overrun, Dbg_State
    );
endinterface

// File: rtl/ppi_portb_mode1_ctrl.sv
// Clocked group-B control decode and Mode 1 strobed handshake sequencer for 8255 Port B.
// Stb_n/Ack_n are synchronised, then edge-detected; every output is a flop except Pb_Oe.
module ppi_portb_mode1_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter bit RESET_DIR_IN = 1'b1
) (
    input logic                   Clk,
    input logic                   Reset_n,
    ppi_portb_mode1_ctrl_if.slave bif
);

    typedef enum logic [2:0] {
        M0        = 3'd0,
        IN_EMPTY  = 3'd1,
        IN_FULL   = 3'd2,
        OUT_EMPTY = 3'd3,
        OUT_FULL  = 3'd4
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] stb_sync_q, ack_sync_q;
    logic                   stb_prev_q, ack_prev_q;
    logic [7:0]             pb_out_q, rd_data_q;
    logic                   mode1_q, dir_in_q, inte_q, ibf_q, obf_n_q, intr_q, overrun_q;
    // Interrupt condition independent of Inte, so a BSR write can re-evaluate Intr.
    logic                   pend_q;

    logic stb_fall, stb_rise, ack_fall, ack_rise;
    logic unused_bus_bits;

    assign unused_bus_bits = ^bif.Bus[6:4];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stb_sync_q <= '1;
            ack_sync_q <= '1;
            stb_prev_q <= 1'b1;
            ack_prev_q <= 1'b1;
        end else begin
            stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], bif.Stb_n};
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bif.Ack_n};
            stb_prev_q <= stb_sync_q[SYNC_STAGES-1];
            ack_prev_q <= ack_sync_q[SYNC_STAGES-1];
        end
    end

    assign stb_fall = stb_prev_q & ~stb_sync_q[SYNC_STAGES-1];
    assign stb_rise = ~stb_prev_q & stb_sync_q[SYNC_STAGES-1];
    assign ack_fall = ack_prev_q & ~ack_sync_q[SYNC_STAGES-1];
    assign ack_rise = ~ack_prev_q & ack_sync_q[SYNC_STAGES-1];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= M0;
            pb_out_q  <= 8'h00;
            rd_data_q <= 8'h00;
            mode1_q   <= 1'b0;
            dir_in_q  <= RESET_DIR_IN;
            inte_q    <= 1'b0;
            ibf_q     <= 1'b0;
            obf_n_q   <= 1'b1;
            intr_q    <= 1'b0;
            overrun_q <= 1'b0;
            pend_q    <= 1'b0;
        end else if (bif.Wr_Ctrl) begin
            if (bif.Bus[7]) begin
                mode1_q   <= bif.Bus[2];
                dir_in_q  <= bif.Bus[1];
                inte_q    <= 1'b0;
                ibf_q     <= 1'b0;
                obf_n_q   <= 1'b1;
                intr_q    <= 1'b0;
                overrun_q <= 1'b0;
                pend_q    <= 1'b0;
                pb_out_q  <= 8'h00;
                if (!bif.Bus[2])     state_q <= M0;
                else if (bif.Bus[1]) state_q <= IN_EMPTY;
                else                 state_q <= OUT_EMPTY;
            end else if (bif.Bus[3:1] == 3'b010) begin
                inte_q <= bif.Bus[0];
                intr_q <= bif.Bus[0] & pend_q;
            end
        end else begin
            case (state_q)
                M0: begin
                    if (dir_in_q)          rd_data_q <= bif.Pin_B;
                    else if (bif.Wr_PortB) pb_out_q  <= bif.Cpu_Data;
                end
                IN_EMPTY: begin
                    if (stb_fall) begin
                        rd_data_q <= bif.Pin_B;
                        ibf_q     <= 1'b1;
                        state_q   <= IN_FULL;
                    end
                end
                IN_FULL: begin
                    // A read retires the old byte before a coincident strobe latches the new one.
                    if (bif.Rd_PortB && stb_fall) begin
                        rd_data_q <= bif.Pin_B;
                        intr_q    <= 1'b0;
                        pend_q    <= 1'b0;
                    end else if (bif.Rd_PortB) begin
                        ibf_q   <= 1'b0;
                        intr_q  <= 1'b0;
                        pend_q  <= 1'b0;
                        state_q <= IN_EMPTY;
                    end else if (stb_fall) begin
                        overrun_q <= 1'b1;
                    end else if (stb_rise) begin
                        pend_q <= 1'b1;
                        intr_q <= inte_q;
                    end
                end
                OUT_EMPTY: begin
                    if (bif.Wr_PortB) begin
                        pb_out_q <= bif.Cpu_Data;
                        obf_n_q  <= 1'b0;
                        intr_q   <= 1'b0;
                        pend_q   <= 1'b0;
                        state_q  <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    // Ack rise only completes the handshake once the fall has released Obf_n.
                    if (bif.Wr_PortB) begin
                        pb_out_q <= bif.Cpu_Data;
                        obf_n_q  <= 1'b0;
                        intr_q   <= 1'b0;
                    end else if (ack_fall) begin
                        obf_n_q <= 1'b1;
                    end else if (ack_rise && obf_n_q) begin
                        pend_q  <= 1'b1;
                        intr_q  <= inte_q;
                        state_q <= OUT_EMPTY;
                    end
                end
                default: state_q <= M0;
            endcase
        end
    end

    assign bif.Pb_Out    = pb_out_q;
    assign bif.Pb_Oe     = ~dir_in_q;
    assign bif.Rd_Data   = rd_data_q;
    assign bif.Mode1     = mode1_q;
    assign bif.Dir_In    = dir_in_q;
    assign bif.Inte      = inte_q;
    assign bif.Ibf       = ibf_q;
    assign bif.Obf_n     = obf_n_q;
    assign bif.Intr      = intr_q;
    assign bif.Overrun   = overrun_q;
    assign bif.Dbg_State = state_q;

endmodule

// File: tb/tb_ppi_portb_mode1_ctrl.sv
// Directed bench for the Port B Mode 1 sequencer: control decode, input/output handshakes,
// coincident events and asynchronous reset mid-handshake.
module tb_ppi_portb_mode1_ctrl;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    ppi_portb_mode1_ctrl_if pif ();

    ppi_portb_mode1_ctrl #(
        .SYNC_STAGES  (2),
        .RESET_DIR_IN (1'b1)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bif     (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ctrl(input logic [7:0] v);
        pif.Bus     = v;
        pif.Wr_Ctrl = 1'b1;
        tick(1);
        pif.Wr_Ctrl = 1'b0;
    endtask

    task automatic wr_b(input logic [7:0] v);
        pif.Cpu_Data = v;
        pif.Wr_PortB = 1'b1;
        tick(1);
        pif.Wr_PortB = 1'b0;
    endtask

    task automatic rd_b();
        pif.Rd_PortB = 1'b1;
        tick(1);
        pif.Rd_PortB = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pb_out"},  pif.Pb_Out,  8'h00);
        chk({tag, "_rd_data"}, pif.Rd_Data, 8'h00);
        chk({tag, "_mode1"},   pif.Mode1,   8'h00);
        chk({tag, "_dir_in"},  pif.Dir_In,  8'h01);
        chk({tag, "_pb_oe"},   pif.Pb_Oe,   8'h00);
        chk({tag, "_inte"},    pif.Inte,    8'h00);
        chk({tag, "_ibf"},     pif.Ibf,     8'h00);
        chk({tag, "_obf_n"},   pif.Obf_n,   8'h01);
        chk({tag, "_intr"},    pif.Intr,    8'h00);
        chk({tag, "_overrun"}, pif.Overrun, 8'h00);
    endtask

    initial begin
        rst_n        = 1'b0;
        pif.Wr_Ctrl  = 1'b0;
        pif.Bus      = 8'h00;
        pif.Wr_PortB = 1'b0;
        pif.Rd_PortB = 1'b0;
        pif.Cpu_Data = 8'h00;
        pif.Pin_B    = 8'h00;
        pif.Stb_n    = 1'b1;
        pif.Ack_n    = 1'b1;
        #12;
        chk_reset_vals("por");
        rst_n = 1'b1;
        tick(2);

        // Mode 0 input samples the pins; Mode 0 output accepts writes.
        pif.Pin_B = 8'hE7;
        tick(1);
        chk("m0_rd_data", pif.Rd_Data, 8'hE7);
        ctrl(8'h80);
        chk("m0_out_pb_oe", pif.Pb_Oe, 8'h01);
        wr_b(8'h3F);
        chk("m0_pb_out", pif.Pb_Out, 8'h3F);

        // Mode 1 input, Inte set by BSR.
        ctrl(8'h86);
        ctrl(8'h05);
        chk("in_mode1", pif.Mode1, 8'h01);
        chk("in_dir",   pif.Dir_In, 8'h01);
        chk("in_inte",  pif.Inte, 8'h01);
        chk("in_pb_oe", pif.Pb_Oe, 8'h00);
        chk("in_ibf0",  pif.Ibf, 8'h00);
        chk("in_intr0", pif.Intr, 8'h00);

        // Strobe low 4 clocks: Ibf exactly 3 clocks after fall, Intr 3 after rise.
        pif.Pin_B = 8'hA5;
        pif.Stb_n = 1'b0;
        tick(2);
        chk("stb_ibf_early", pif.Ibf, 8'h00);
        tick(1);
        chk("stb_ibf", pif.Ibf, 8'h01);
        chk("stb_rd_data", pif.Rd_Data, 8'hA5);
        tick(1);
        pif.Stb_n = 1'b1;
        pif.Pin_B = 8'h3C;
        tick(2);
        chk("stb_intr_early", pif.Intr, 8'h00);
        tick(1);
        chk("stb_intr", pif.Intr, 8'h01);

        // Second strobe without a read: overrun, data kept.
        pif.Stb_n = 1'b0;
        tick(3);
        chk("ovr_flag", pif.Overrun, 8'h01);
        chk("ovr_rd_data", pif.Rd_Data, 8'hA5);
        pif.Stb_n = 1'b1;
        tick(3);
        rd_b();
        chk("rd_ibf", pif.Ibf, 8'h00);
        chk("rd_intr", pif.Intr, 8'h00);
        chk("rd_hold", pif.Rd_Data, 8'hA5);
        chk("ovr_sticky", pif.Overrun, 8'h01);
        ctrl(8'h86);
        chk("ovr_cleared", pif.Overrun, 8'h00);

        // Inte=0 after mode set; pending input interrupt follows later BSR writes.
        pif.Pin_B = 8'h77;
        pif.Stb_n = 1'b0;
        tick(3);
        chk("in2_rd_data", pif.Rd_Data, 8'h77);
        pif.Stb_n = 1'b1;
        tick(3);
        chk("in2_intr_masked", pif.Intr, 8'h00);
        ctrl(8'h05);
        chk("bsr_intr_on", pif.Intr, 8'h01);
        ctrl(8'h04);
        chk("bsr_intr_off", pif.Intr, 8'h00);

        // Read coincident with the synchronised strobe fall.
        pif.Pin_B = 8'h99;
        pif.Stb_n = 1'b0;
        tick(2);
        pif.Rd_PortB = 1'b1;
        tick(1);
        pif.Rd_PortB = 1'b0;
        chk("rdstb_ibf", pif.Ibf, 8'h01);
        chk("rdstb_rd_data", pif.Rd_Data, 8'h99);
        chk("rdstb_overrun", pif.Overrun, 8'h00);
        chk("rdstb_intr", pif.Intr, 8'h00);
        pif.Stb_n = 1'b1;
        tick(3);
        wr_b(8'hF0);
        chk("in_wr_ignored", pif.Pb_Out, 8'h00);
        rd_b();

        // Mode 1 output handshake.
        ctrl(8'h84);
        ctrl(8'h05);
        chk("out_pb_oe", pif.Pb_Oe, 8'h01);
        chk("out_obf_idle", pif.Obf_n, 8'h01);
        wr_b(8'h5A);
        chk("out_pb_out", pif.Pb_Out, 8'h5A);
        chk("out_obf", pif.Obf_n, 8'h00);
        pif.Ack_n = 1'b0;
        tick(2);
        chk("ack_obf_early", pif.Obf_n, 8'h00);
        tick(1);
        chk("ack_obf", pif.Obf_n, 8'h01);
        tick(1);
        pif.Ack_n = 1'b1;
        tick(2);
        chk("ack_intr_early", pif.Intr, 8'h00);
        tick(1);
        chk("ack_intr", pif.Intr, 8'h01);

        // Write coincident with the synchronised ack fall.
        wr_b(8'h11);
        chk("wr_clr_intr", pif.Intr, 8'h00);
        pif.Ack_n = 1'b0;
        tick(2);
        pif.Cpu_Data = 8'hC3;
        pif.Wr_PortB = 1'b1;
        tick(1);
        pif.Wr_PortB = 1'b0;
        chk("wrack_obf", pif.Obf_n, 8'h00);
        chk("wrack_pb_out", pif.Pb_Out, 8'hC3);
        pif.Ack_n = 1'b1;
        tick(3);
        chk("wrack_rise_obf", pif.Obf_n, 8'h00);
        chk("wrack_rise_intr", pif.Intr, 8'h00);
        pif.Ack_n = 1'b0;
        tick(3);
        pif.Ack_n = 1'b1;
        tick(3);
        chk("ack2_intr", pif.Intr, 8'h01);
        ctrl(8'h04);
        chk("ack2_bsr_off", pif.Intr, 8'h00);

        // Same coincident write with Inte = 0: Intr never asserts.
        wr_b(8'h22);
        pif.Ack_n = 1'b0;
        tick(2);
        pif.Cpu_Data = 8'h44;
        pif.Wr_PortB = 1'b1;
        tick(1);
        pif.Wr_PortB = 1'b0;
        chk("noint_obf", pif.Obf_n, 8'h00);
        chk("noint_pb_out", pif.Pb_Out, 8'h44);
        pif.Ack_n = 1'b1;
        tick(3);
        pif.Ack_n = 1'b0;
        tick(3);
        chk("noint_obf_rel", pif.Obf_n, 8'h01);
        pif.Ack_n = 1'b1;
        tick(3);
        chk("noint_intr", pif.Intr, 8'h00);

        // Asynchronous reset in IN_FULL, no clock edge in the window.
        ctrl(8'h86);
        pif.Pin_B = 8'h55;
        pif.Stb_n = 1'b0;
        tick(3);
        chk("pre_rst_in_ibf", pif.Ibf, 8'h01);
        pif.Stb_n = 1'b1;
        pif.Pin_B = 8'h00;
        rst_n = 1'b0;
        #2;
        chk_reset_vals("rst_in");
        rst_n = 1'b1;
        tick(3);

        // Asynchronous reset in OUT_FULL.
        ctrl(8'h84);
        wr_b(8'h5A);
        chk("pre_rst_out_obf", pif.Obf_n, 8'h00);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("rst_out");
        rst_n = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
